position_integrator: RTL and testbench

- Multi-channel signed position accumulator for the command module's per-axis position state.
- Each accepted request adds a signed delta to one channel, chosen by a one-hot select.
- The add is bit-serial: one full-adder slice plus a carry flop, LSB first, over WIDTH cycles.
- Optional saturation on two's-complement overflow; all channel positions are exported flat for navigation logic.

---
 rtl/position_integrator_pkg.sv | 33 +++
 rtl/serial_adder_bit.sv | 37 +++
 rtl/position_integrator.sv | 169 ++++++++++++++++
 tb/tb_position_integrator.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/position_integrator_pkg.sv
// Shared types and constants for the multi-channel serial position integrator.
//   state_e          : FSM encoding (idle / bit-serial shift / commit)
//   DefaultWidth     : default position and delta width
//   DefaultChannels  : default number of position channels
//   sat_max/sat_min  : saturation patterns for a given width (up to 64 bits)
//   cnt_width()      : bit-counter width for a given operand width
package position_integrator_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth    = 8;
  localparam int unsigned DefaultChannels = 4;

  // Largest positive two's-complement value, right-aligned in 64 bits.
  function automatic logic [63:0] sat_max(input int unsigned width);
    sat_max = (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value, right-aligned in 64 bits.
  function automatic logic [63:0] sat_min(input int unsigned width);
    sat_min = 64'd1 << (width - 1);
  endfunction

  // Counter must index bits 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    cnt_width = (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_bit.sv
// One full-adder slice with a registered carry for LSB-first serial addition.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : clears the carry ahead of a new operation
//   en         : advances the carry by one bit position
//   a, b       : operand bits for the current position
//   sum        : a ^ b ^ carry
//   c_in       : carry into the current bit position
//   c_next     : carry out of the current bit position
module serial_adder_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic c_in,
  output logic c_next
);

  logic c_q;

  assign c_in   = c_q;
  assign sum    = a ^ b ^ c_q;
  assign c_next = (a & b) | (c_q & (a ^ b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= 1'b0;
    end else if (load) begin
      c_q <= 1'b0;
    end else if (en) begin
      c_q <= c_next;
    end
  end

endmodule

// File: rtl/position_integrator.sv
// Multi-channel signed position accumulator with a bit-serial adder.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake; ready only while idle
//   ch_sel, delta       : one-hot target channel and signed increment
//   clear_all           : synchronous clear of all channels, aborts any op
//   out_valid           : one-cycle pulse when a result is committed
//   out_ch/out_pos      : committed channel and new position (held afterwards)
//   out_sat             : committed result was clamped
//   err                 : one-cycle pulse for an accepted illegal ch_sel
//   pos_flat            : all stored positions, channel i at [i*WIDTH +: WIDTH]
module position_integrator
  import position_integrator_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned CHANNELS = DefaultChannels,
  parameter bit          SAT_EN   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS-1:0]       ch_sel,
  input  logic [WIDTH-1:0]          delta,
  input  logic                      clear_all,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       out_ch,
  output logic [WIDTH-1:0]          out_pos,
  output logic                      out_sat,
  output logic                      err,
  output logic [CHANNELS*WIDTH-1:0] pos_flat
);

  localparam int unsigned     CntW   = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]    SatMax = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0]    SatMin = WIDTH'(sat_min(WIDTH));
  localparam logic [CHANNELS-1:0] ChOne  = CHANNELS'(1);

  state_e state_q, state_d;

  logic [WIDTH-1:0]    pos_q [CHANNELS];
  logic [WIDTH-1:0]    a_q, b_q, res_q;
  logic                b_neg_q;
  logic [CHANNELS-1:0] ch_q;
  logic [CntW-1:0]     cnt_q;
  logic                c_msb_q, c_out_q;
  logic                err_q;
  logic [WIDTH-1:0]    out_pos_q;
  logic [CHANNELS-1:0] out_ch_q;
  logic                out_sat_q;

  logic             hs, sel_legal, last_bit;
  logic [WIDTH-1:0] rd_pos, done_pos;
  logic             sat_hit;
  logic             sum_bit, c_in_bit, c_next_bit;

  assign in_ready  = (state_q == StIdle);
  assign hs        = in_valid & in_ready;
  assign sel_legal = (ch_sel != '0) && ((ch_sel & (ch_sel - ChOne)) == '0);
  assign last_bit  = (cnt_q == CntMax);

  // One-hot read mux; only meaningful when sel_legal.
  always_comb begin
    rd_pos = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel[i]) rd_pos = rd_pos | pos_q[i];
    end
  end

  serial_adder_bit u_adder (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (hs | clear_all),
    .en     (state_q == StShift),
    .a      (a_q[0]),
    .b      (b_q[0]),
    .sum    (sum_bit),
    .c_in   (c_in_bit),
    .c_next (c_next_bit)
  );

  // Overflow only happens when both operands share a sign, so B's sign picks the clamp.
  assign sat_hit  = SAT_EN && (c_msb_q ^ c_out_q);
  assign done_pos = sat_hit ? (b_neg_q ? SatMin : SatMax) : res_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs && sel_legal) state_d = StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear_all) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= hs && !sel_legal && !clear_all;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) pos_q[i] <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      b_neg_q   <= 1'b0;
      ch_q      <= '0;
      cnt_q     <= '0;
      c_msb_q   <= 1'b0;
      c_out_q   <= 1'b0;
      out_pos_q <= '0;
      out_ch_q  <= '0;
      out_sat_q <= 1'b0;
    end else if (clear_all) begin
      for (int i = 0; i < CHANNELS; i++) pos_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hs && sel_legal) begin
            a_q     <= rd_pos;
            b_q     <= delta;
            b_neg_q <= delta[WIDTH-1];
            ch_q    <= ch_sel;
            cnt_q   <= '0;
          end
        end
        StShift: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {sum_bit, res_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CntW'(1);
          if (last_bit) begin
            c_msb_q <= c_in_bit;
            c_out_q <= c_next_bit;
          end
        end
        StDone: begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (ch_q[i]) pos_q[i] <= done_pos;
          end
          out_pos_q <= done_pos;
          out_ch_q  <= ch_q;
          out_sat_q <= sat_hit;
        end
        default: ;
      endcase
    end
  end

  // Results are visible during DONE and held from the registers afterwards.
  assign out_valid = (state_q == StDone);
  assign out_pos   = out_valid ? done_pos : out_pos_q;
  assign out_ch    = out_valid ? ch_q : out_ch_q;
  assign out_sat   = out_valid ? sat_hit : out_sat_q;
  assign err       = err_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_flat
    assign pos_flat[g*WIDTH +: WIDTH] = pos_q[g];
  end

endmodule

// File: tb/tb_position_integrator.sv
module tb_position_integrator;

  localparam int unsigned W = 8;
  localparam int unsigned C = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         clear_all = 1'b0;
  logic [C-1:0] ch_sel = '0;
  logic [W-1:0] delta = '0;

  logic           in_ready, out_valid, out_sat, err;
  logic [C-1:0]   out_ch;
  logic [W-1:0]   out_pos;
  logic [C*W-1:0] pos_flat;

  logic           w_in_ready, w_out_valid, w_out_sat, w_err;
  logic [C-1:0]   w_out_ch;
  logic [W-1:0]   w_out_pos;
  logic [C*W-1:0] w_pos_flat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  position_integrator #(.WIDTH(W), .CHANNELS(C), .SAT_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ch_sel    (ch_sel),
    .delta     (delta),
    .clear_all (clear_all),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_pos   (out_pos),
    .out_sat   (out_sat),
    .err       (err),
    .pos_flat  (pos_flat)
  );

  position_integrator #(.WIDTH(W), .CHANNELS(C), .SAT_EN(1'b0)) dut_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .ch_sel    (ch_sel),
    .delta     (delta),
    .clear_all (clear_all),
    .out_valid (w_out_valid),
    .out_ch    (w_out_ch),
    .out_pos   (w_out_pos),
    .out_sat   (w_out_sat),
    .err       (w_err),
    .pos_flat  (w_pos_flat)
  );

  // Drives one request and waits (bounded) for its commit; returns what was seen.
  task automatic do_op(input logic [C-1:0] ch, input logic [W-1:0] d, output int lat,
                       output logic [W-1:0] p, output logic s, output logic [C-1:0] oc,
                       output logic [W-1:0] wp, output logic ws);
    in_valid = 1'b1;
    ch_sel   = ch;
    delta    = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    p  = out_pos;
    s  = out_sat;
    oc = out_ch;
    wp = w_out_pos;
    ws = w_out_sat;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (pos_flat !== 32'h0) begin
      errors++; $display("FAIL reset_pos_flat: got %h want 00000000", pos_flat);
    end
    checks++;
    if ({in_ready, out_valid, out_sat, err, out_ch, out_pos} !== {4'b1000, 4'h0, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b sat=%b err=%b ch=%b pos=%h want 1 0 0 0 0 0",
               in_ready, out_valid, out_sat, err, out_ch, out_pos);
    end
    checks++;
    if ({w_in_ready, w_out_valid, w_err, w_out_ch} !== {3'b100, 4'h0}) begin
      errors++; $display("FAIL reset_wrap_outputs: got rdy=%b ov=%b err=%b ch=%b want 1 0 0 0",
                         w_in_ready, w_out_valid, w_err, w_out_ch);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat; logic [W-1:0] p, wp; logic s, ws; logic [C-1:0] oc;
    do_op(4'b0001, 8'd5, lat, p, s, oc, wp, ws);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
    checks++;
    if (p !== 8'h05 || s !== 1'b0 || oc !== 4'b0001) begin
      errors++; $display("FAIL basic_result: got pos=%h sat=%b ch=%b want 05 0 0001", p, s, oc);
    end
    checks++;
    if (pos_flat[7:0] !== 8'h05) begin
      errors++; $display("FAIL basic_pos_flat: got %h want 05", pos_flat[7:0]);
    end
    checks++;
    if (out_valid !== 1'b0 || out_pos !== 8'h05 || out_ch !== 4'b0001) begin
      errors++; $display("FAIL basic_hold: got ov=%b pos=%h ch=%b want 0 05 0001",
                         out_valid, out_pos, out_ch);
    end
    // Zero delta is a full-length op that leaves the position unchanged.
    do_op(4'b0001, 8'd0, lat, p, s, oc, wp, ws);
    checks++;
    if (lat !== 8 || p !== 8'h05) begin
      errors++; $display("FAIL zero_delta: got lat=%0d pos=%h want 8 05", lat, p);
    end
  endtask

  task automatic test_pos_sat;
    int lat; logic [W-1:0] p, wp; logic s, ws; logic [C-1:0] oc;
    do_op(4'b0010, 8'd120, lat, p, s, oc, wp, ws);
    checks++;
    if (p !== 8'd120 || wp !== 8'd120) begin
      errors++; $display("FAIL pos_preload: got %h/%h want 78/78", p, wp);
    end
    do_op(4'b0010, 8'd10, lat, p, s, oc, wp, ws);
    checks++;
    if (p !== 8'h7f || s !== 1'b1) begin
      errors++; $display("FAIL pos_sat_clamp: got pos=%h sat=%b want 7f 1", p, s);
    end
    checks++;
    if (wp !== 8'h82 || ws !== 1'b0) begin
      errors++; $display("FAIL pos_sat_wrap: got pos=%h sat=%b want 82 0", wp, ws);
    end
    checks++;
    if (pos_flat[15:8] !== 8'h7f || w_pos_flat[15:8] !== 8'h82) begin
      errors++; $display("FAIL pos_sat_stored: got %h/%h want 7f/82",
                         pos_flat[15:8], w_pos_flat[15:8]);
    end
  endtask

  task automatic test_neg_sat;
    int lat; logic [W-1:0] p, wp; logic s, ws; logic [C-1:0] oc;
    do_op(4'b0100, 8'h9c, lat, p, s, oc, wp, ws);
    checks++;
    if (p !== 8'h9c || s !== 1'b0) begin
      errors++; $display("FAIL neg_preload: got pos=%h sat=%b want 9c 0", p, s);
    end
    do_op(4'b0100, 8'hce, lat, p, s, oc, wp, ws);
    checks++;
    if (p !== 8'h80 || s !== 1'b1 || oc !== 4'b0100) begin
      errors++; $display("FAIL neg_sat_clamp: got pos=%h sat=%b ch=%b want 80 1 0100", p, s, oc);
    end
    checks++;
    if (wp !== 8'h6a || ws !== 1'b0) begin
      errors++; $display("FAIL neg_sat_wrap: got pos=%h sat=%b want 6a 0", wp, ws);
    end
    do_op(4'b0100, 8'h01, lat, p, s, oc, wp, ws);
    checks++;
    if (p !== 8'h81 || s !== 1'b0 || wp !== 8'h6b) begin
      errors++; $display("FAIL neg_followup: got pos=%h sat=%b wrap=%h want 81 0 6b", p, s, wp);
    end
  endtask

  task automatic test_illegal_sel;
    logic [C-1:0] sels [2];
    int nov;
    sels[0] = 4'b0101;
    sels[1] = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      ch_sel   = sels[k];
      delta    = 8'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL illegal_err_%0d: got err=%b rdy=%b ov=%b want 1 1 0",
                           k, err, in_ready, out_valid);
      end
      nov = 0;
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL illegal_pulse_%0d: got %b want 0", k, err); end
      for (int i = 0; i < 10; i++) begin
        if (out_valid) nov++;
        @(posedge clk); #1;
      end
      checks++;
      if (nov !== 0 || pos_flat !== 32'h00817f05) begin
        errors++; $display("FAIL illegal_no_change_%0d: got ov_count=%0d flat=%h want 0 00817f05",
                           k, nov, pos_flat);
      end
    end
  endtask

  task automatic test_back_to_back;
    int hs_cyc [3];
    logic [W-1:0] vals [3];
    int nhs = 0;
    int nov = 0;
    for (int i = 0; i < 3; i++) begin hs_cyc[i] = 0; vals[i] = '0; end
    in_valid = 1'b1;
    ch_sel   = 4'b1000;
    delta    = 8'd1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_valid && in_ready && nhs < 3) begin hs_cyc[nhs] = cyc; nhs++; end
      @(posedge clk); #1;
      if (nhs == 3) in_valid = 1'b0;
      if (out_valid) begin
        if (nov < 3) vals[nov] = out_pos;
        nov++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nhs !== 3 || hs_cyc[1] - hs_cyc[0] !== 10 || hs_cyc[2] - hs_cyc[1] !== 10) begin
      errors++; $display("FAIL b2b_spacing: got n=%0d at %0d,%0d,%0d want 3 spaced 10",
                         nhs, hs_cyc[0], hs_cyc[1], hs_cyc[2]);
    end
    checks++;
    if (nov !== 3 || vals[0] !== 8'd1 || vals[1] !== 8'd2 || vals[2] !== 8'd3) begin
      errors++; $display("FAIL b2b_values: got n=%0d %h,%h,%h want 3 01,02,03",
                         nov, vals[0], vals[1], vals[2]);
    end
  endtask

  task automatic test_clear_abort;
    int lat, nov; logic [W-1:0] p, wp; logic s, ws; logic [C-1:0] oc;
    in_valid = 1'b1;
    ch_sel   = 4'b0001;
    delta    = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    clear_all = 1'b1;
    @(posedge clk); #1;
    clear_all = 1'b0;
    checks++;
    if (pos_flat !== 32'h0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL clear_abort_state: got flat=%h rdy=%b ov=%b want 0 1 0",
                         pos_flat, in_ready, out_valid);
    end
    nov = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) nov++;
      @(posedge clk); #1;
    end
    checks++;
    if (nov !== 0) begin errors++; $display("FAIL clear_no_valid: got %0d want 0", nov); end
    do_op(4'b0001, 8'd7, lat, p, s, oc, wp, ws);
    checks++;
    if (p !== 8'd7) begin errors++; $display("FAIL clear_next_op: got %h want 07", p); end
    // Clear wins over a simultaneous handshake, which is dropped silently.
    in_valid  = 1'b1;
    ch_sel    = 4'b0010;
    delta     = 8'd5;
    clear_all = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    clear_all = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || err !== 1'b0 || pos_flat !== 32'h0) begin
      errors++; $display("FAIL clear_priority: got rdy=%b err=%b flat=%h want 1 0 0",
                         in_ready, err, pos_flat);
    end
  endtask

  task automatic test_reset_midop;
    int lat, nov; logic [W-1:0] p, wp; logic s, ws; logic [C-1:0] oc;
    do_op(4'b0001, 8'd4, lat, p, s, oc, wp, ws);
    in_valid = 1'b1;
    ch_sel   = 4'b0100;
    delta    = 8'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    checks++;
    if (pos_flat !== 32'h0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_pos !== 8'h0) begin
      errors++; $display("FAIL reset_midop_state: got flat=%h rdy=%b ov=%b pos=%h want 0 1 0 0",
                         pos_flat, in_ready, out_valid, out_pos);
    end
    #4;
    rst_n = 1'b1;
    @(posedge clk); #1;
    nov = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) nov++;
      @(posedge clk); #1;
    end
    checks++;
    if (nov !== 0) begin errors++; $display("FAIL reset_no_valid: got %0d want 0", nov); end
    do_op(4'b0001, 8'd7, lat, p, s, oc, wp, ws);
    checks++;
    if (p !== 8'd7 || lat !== 8) begin
      errors++; $display("FAIL reset_next_op: got pos=%h lat=%0d want 07 8", p, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_sat();
    test_illegal_sel();
    test_back_to_back();
    test_clear_abort();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
